// File: rtl/grid_pkg.sv
// Shared types and defaults for the grid mover (directions, FSM states).
package grid_pkg;

  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;

  typedef enum logic [1:0] {IDLE, HOP, HOLD} mover_state_t;

  localparam int DEF_CELL_PX = 32;
  localparam int DEF_COLS    = 20;
  localparam int DEF_ROWS    = 15;

  // Button vector order is {up, down, left, right}; up wins, right loses.
  function automatic dir_t pick_dir(input logic [3:0] btn);
    if (btn[3])      return UP;
    else if (btn[2]) return DOWN;
    else if (btn[1]) return LEFT;
    else if (btn[0]) return RIGHT;
    else             return NONE;
  endfunction

  function automatic logic dir_held(input logic [3:0] btn, input dir_t d);
    case (d)
      UP:      return btn[3];
      DOWN:    return btn[2];
      LEFT:    return btn[1];
      RIGHT:   return btn[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/grid_mover_if.sv
// Player-side bundle of the grid mover: raw buttons and respawn in,
// grid/pixel position and status out. The mover uses the slave side.
interface grid_mover_if
  import grid_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
);
  logic                     btn_up;
  logic                     btn_down;
  logic                     btn_left;
  logic                     btn_right;
  logic                     respawn;
  logic [$clog2(COLS)-1:0]  col;
  logic [$clog2(ROWS)-1:0]  row;
  logic [9:0]               pos_x;
  logic [9:0]               pos_y;
  logic                     moving;
  logic                     move_pulse;
  logic                     blocked_pulse;
  logic                     at_goal;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, respawn,
    input  col, row, pos_x, pos_y, moving, move_pulse, blocked_pulse, at_goal
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, respawn,
    output col, row, pos_x, pos_y, moving, move_pulse, blocked_pulse, at_goal
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-button debouncer: the output takes the input value only after the
// two have disagreed for DEBOUNCE_CYC consecutive cycles; any agreement
// in between restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic btn_o
);
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;

  // Count disagreeing cycles; flip the output on the terminal count.
  always_comb begin
    cnt_d = '0;
    btn_d = btn_q;
    if (btn_i != btn_q) begin
      if (cnt_q == CNT_TC) begin
        btn_d = btn_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      btn_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      btn_q <= btn_d;
    end
  end

  assign btn_o = btn_q;
endmodule

// File: rtl/grid_mover.sv
// Grid-locked player mover: debounced buttons become one-cell moves with
// hop lock-out, hold-to-repeat, respawn and edge/goal status.
// Optional horizontal wrap-around when WRAP_X_EN is defined.
//
// state | meaning
// IDLE  | waiting for a rising edge of the winning button
// HOP   | move just made, new moves locked out until hop timer expires
// HOLD  | same direction still held, repeat timer running
module grid_mover
  import grid_pkg::*;
#(
  parameter int CELL_PX      = DEF_CELL_PX,
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int START_COL    = 10,
  parameter int START_ROW    = 14,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int HOP_CYC      = 1000000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic         clk,
  input  logic         reset,
  grid_mover_if.slave  bus
);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int SHIFT = $clog2(CELL_PX);
  localparam int HW    = (HOP_CYC > 1) ? $clog2(HOP_CYC) : 1;
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW    = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_START = CW'(START_COL);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [HW-1:0] HOP_LOAD  = HW'(HOP_CYC - 1);
  localparam logic [TW-1:0] DLY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LOAD = TW'(REPEAT_RATE - 1);

  if ((COLS - 1) * CELL_PX >= 1024) begin : g_chk_px_range
    $error("grid_mover: (COLS-1)*CELL_PX must stay below 1024");
  end
  if ((CELL_PX & (CELL_PX - 1)) != 0) begin : g_chk_cell_pow2
    $error("grid_mover: CELL_PX must be a power of two");
  end

  logic [3:0]   db;
  logic [3:0]   db_prev_q;
  dir_t         win, try_dir, dir_q, dir_d;
  logic         win_rise;
  mover_state_t state_q, state_d;
  logic [HW-1:0] hop_q, hop_d;
  logic [TW-1:0] rep_q, rep_d;
  logic          fast_q, fast_d;
  logic [CW-1:0] col_q, col_d, mv_col;
  logic [RW-1:0] row_q, row_d, mv_row;
  logic          mv_ok;
  logic          move_q, move_d, blk_q, blk_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up
    (.clk(clk), .reset(reset), .btn_i(bus.btn_up),    .btn_o(db[3]));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down
    (.clk(clk), .reset(reset), .btn_i(bus.btn_down),  .btn_o(db[2]));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left
    (.clk(clk), .reset(reset), .btn_i(bus.btn_left),  .btn_o(db[1]));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right
    (.clk(clk), .reset(reset), .btn_i(bus.btn_right), .btn_o(db[0]));

  assign win      = pick_dir(db);
  assign win_rise = dir_held(db, win) && !dir_held(db_prev_q, win);
  // In HOLD the attempt always uses the latched direction (it equals win there).
  assign try_dir  = (state_q == IDLE) ? win : dir_q;

  // Candidate cell for a move in try_dir, and whether the grid edge allows it.
  always_comb begin
    mv_ok  = 1'b0;
    mv_col = col_q;
    mv_row = row_q;
    case (try_dir)
      UP: if (row_q != '0) begin
        mv_ok  = 1'b1;
        mv_row = row_q - RW'(1);
      end
      DOWN: if (row_q != ROW_MAX) begin
        mv_ok  = 1'b1;
        mv_row = row_q + RW'(1);
      end
      LEFT: begin
`ifdef WRAP_X_EN
        mv_ok  = 1'b1;
        mv_col = (col_q == '0) ? COL_MAX : col_q - CW'(1);
`else
        if (col_q != '0) begin
          mv_ok  = 1'b1;
          mv_col = col_q - CW'(1);
        end
`endif
      end
      RIGHT: begin
`ifdef WRAP_X_EN
        mv_ok  = 1'b1;
        mv_col = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
`else
        if (col_q != COL_MAX) begin
          mv_ok  = 1'b1;
          mv_col = col_q + CW'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  // Next-state, timers, coordinates and pulses; respawn overrides everything.
  always_comb begin
    state_d = state_q;
    hop_d   = hop_q;
    rep_d   = rep_q;
    dir_d   = dir_q;
    fast_d  = fast_q;
    col_d   = col_q;
    row_d   = row_q;
    move_d  = 1'b0;
    blk_d   = 1'b0;
    if (bus.respawn) begin
      state_d = IDLE;
      hop_d   = '0;
      rep_d   = '0;
      dir_d   = NONE;
      fast_d  = 1'b0;
      col_d   = COL_START;
      row_d   = ROW_START;
    end else begin
      case (state_q)
        IDLE: if (win_rise) begin
          if (mv_ok) begin
            col_d   = mv_col;
            row_d   = mv_row;
            move_d  = 1'b1;
            state_d = HOP;
            hop_d   = HOP_LOAD;
            dir_d   = win;
            fast_d  = 1'b0;
          end else begin
            blk_d = 1'b1;
          end
        end
        HOP: begin
          if (hop_q == '0) begin
            if (win == dir_q) begin
              state_d = HOLD;
              rep_d   = fast_q ? RATE_LOAD : DLY_LOAD;
            end else begin
              state_d = IDLE;
              dir_d   = NONE;
            end
          end else begin
            hop_d = hop_q - HW'(1);
          end
        end
        HOLD: begin
          if (win != dir_q) begin
            state_d = IDLE;
            dir_d   = NONE;
            rep_d   = '0;
          end else if (rep_q == '0) begin
            if (mv_ok) begin
              col_d   = mv_col;
              row_d   = mv_row;
              move_d  = 1'b1;
              state_d = HOP;
              hop_d   = HOP_LOAD;
              fast_d  = 1'b1;
            end else begin
              blk_d = 1'b1;
              rep_d = RATE_LOAD;
            end
          end else begin
            rep_d = rep_q - TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state, timers, position and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hop_q     <= '0;
      rep_q     <= '0;
      dir_q     <= NONE;
      fast_q    <= 1'b0;
      col_q     <= COL_START;
      row_q     <= ROW_START;
      move_q    <= 1'b0;
      blk_q     <= 1'b0;
      db_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      hop_q     <= hop_d;
      rep_q     <= rep_d;
      dir_q     <= dir_d;
      fast_q    <= fast_d;
      col_q     <= col_d;
      row_q     <= row_d;
      move_q    <= move_d;
      blk_q     <= blk_d;
      db_prev_q <= db;
    end
  end

  assign bus.col           = col_q;
  assign bus.row           = row_q;
  assign bus.pos_x         = 10'(col_q) << SHIFT;
  assign bus.pos_y         = 10'(row_q) << SHIFT;
  assign bus.moving        = (state_q == HOP);
  assign bus.move_pulse    = move_q;
  assign bus.blocked_pulse = blk_q;
  assign bus.at_goal       = (row_q == '0);
endmodule

// File: tb/tb_grid_mover.sv
// Directed bench for grid_mover with short timing parameters
// (debounce 4, hop 8, repeat delay 20, repeat rate 10).
module tb_grid_mover;
  import grid_pkg::*;

`ifdef WRAP_X_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  grid_mover_if #(.COLS(20), .ROWS(15)) bus ();

  grid_mover #(
    .CELL_PX(32), .COLS(20), .ROWS(15), .START_COL(10), .START_ROW(14),
    .DEBOUNCE_CYC(4), .HOP_CYC(8), .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btns;     // {up, down, left, right}
    int         exp_col;
    int         exp_row;
    int         exp_mv;
    int         exp_bl;
  } vec_t;

  vec_t vecs[11];
  int   mv_t[$];
  int   mv_cnt, bl_cnt, mov_cnt;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] b);
    bus.btn_up    = b[3];
    bus.btn_down  = b[2];
    bus.btn_left  = b[1];
    bus.btn_right = b[0];
  endtask

  // Hold b for nhold cycles, release for nafter; log pulses by cycle index.
  task automatic hold_run(input logic [3:0] b, input int nhold, input int nafter);
    mv_t.delete();
    mv_cnt = 0; bl_cnt = 0; mov_cnt = 0;
    set_btns(b);
    for (int i = 1; i <= nhold + nafter; i++) begin
      if (i == nhold + 1) set_btns(4'b0000);
      step();
      if (bus.move_pulse) begin mv_cnt++; mv_t.push_back(i); end
      if (bus.blocked_pulse) bl_cnt++;
      if (bus.moving) mov_cnt++;
    end
  endtask

  task automatic do_respawn();
    bus.respawn = 1'b1;
    step();
    bus.respawn = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int c, input int r);
    check({tag, "_col"}, int'(bus.col), c);
    check({tag, "_row"}, int'(bus.row), r);
    check({tag, "_pos_x"}, int'(bus.pos_x), c * 32);
    check({tag, "_pos_y"}, int'(bus.pos_y), r * 32);
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 10, 13, 1, 0};
    vecs[1]  = '{4'b0100, 10, 14, 1, 0};
    vecs[2]  = '{4'b0100, 10, 14, 0, 1};
    vecs[3]  = '{4'b0010,  9, 14, 1, 0};
    vecs[4]  = '{4'b0001, 10, 14, 1, 0};
    vecs[5]  = '{4'b1010, 10, 13, 1, 0};
    vecs[6]  = '{4'b0101, 10, 14, 1, 0};
    vecs[7]  = '{4'b0011,  9, 14, 1, 0};
    vecs[8]  = '{4'b1100,  9, 13, 1, 0};
    vecs[9]  = '{4'b0100,  9, 14, 1, 0};
    vecs[10] = '{4'b0001, 10, 14, 1, 0};

    reset = 1'b1;
    set_btns(4'b0000);
    bus.respawn = 1'b0;
    step(); step();
    check_pos("rst", 10, 14);
    check("rst_moving", int'(bus.moving), 0);
    check("rst_move_pulse", int'(bus.move_pulse), 0);
    check("rst_blocked", int'(bus.blocked_pulse), 0);
    check("rst_at_goal", int'(bus.at_goal), 0);
    reset = 1'b0;
    step();

    // Clean up press: one move five cycles later, eight cycles of HOP.
    hold_run(4'b1000, 10, 20);
    check("up_moves", mv_cnt, 1);
    check("up_latency", mv_t[0], 5);
    check("up_moving_cycles", mov_cnt, 8);
    check_pos("up", 10, 13);

    // Short pulses never survive the debouncer.
    mv_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      set_btns(4'b1000);
      for (int j = 0; j < 2; j++) begin step(); if (bus.move_pulse) mv_cnt++; end
      set_btns(4'b0000);
      step(); if (bus.move_pulse) mv_cnt++;
    end
    for (int j = 0; j < 20; j++) begin step(); if (bus.move_pulse) mv_cnt++; end
    check("glitch_moves", mv_cnt, 0);
    check("glitch_row", int'(bus.row), 13);

    do_respawn();
    check_pos("respawn1", 10, 14);

    for (int i = 0; i < 11; i++) begin
      hold_run(vecs[i].btns, 10, 30);
      check_pos($sformatf("vec%0d", i), vecs[i].exp_col, vecs[i].exp_row);
      check($sformatf("vec%0d_moves", i), mv_cnt, vecs[i].exp_mv);
      check($sformatf("vec%0d_blocked", i), bl_cnt, vecs[i].exp_bl);
    end

    // Hold right: first move at 5, then +28 (hop+delay), then +18 each.
    hold_run(4'b0001, 180, 30);
    check("hold_r_moves", mv_cnt, WRAP ? 10 : 9);
    check("hold_r_blocked", bl_cnt, WRAP ? 0 : 1);
    check("hold_r_t0", mv_t[0], 5);
    check("hold_r_t1", mv_t[1], 33);
    check("hold_r_t2", mv_t[2], 51);
    check("hold_r_t8", mv_t[8], 159);
    check("hold_r_col", int'(bus.col), WRAP ? 0 : 19);

    // Walk to col 0, then a single left tap at the edge.
    do_respawn();
    hold_run(4'b0010, 180, 30);
    check("hold_l_moves", mv_cnt, 10);
    check("hold_l_col", int'(bus.col), 0);
    hold_run(4'b0010, 10, 30);
    check("edge_l_moves", mv_cnt, WRAP ? 1 : 0);
    check("edge_l_blocked", bl_cnt, WRAP ? 0 : 1);
    check_pos("edge_l", WRAP ? 19 : 0, 14);

    // Reach (11,5), then respawn during the hop onto (12,5).
    do_respawn();
    hold_run(4'b1000, 160, 30);
    check("hold_u_moves", mv_cnt, 9);
    hold_run(4'b0001, 10, 30);
    check_pos("pre_hop", 11, 5);
    set_btns(4'b0001);
    mv_cnt = 0;
    for (int j = 0; j < 12 && mv_cnt == 0; j++) begin
      step();
      if (bus.move_pulse) mv_cnt++;
    end
    check("hop_press_seen", mv_cnt, 1);
    check_pos("hop", 12, 5);
    step(); step();
    check("hop_moving", int'(bus.moving), 1);
    do_respawn();
    check_pos("respawn_hop", 10, 14);
    check("respawn_moving", int'(bus.moving), 0);
    check("respawn_move_pulse", int'(bus.move_pulse), 0);
    mv_cnt = 0;
    for (int j = 0; j < 20; j++) begin step(); if (bus.move_pulse) mv_cnt++; end
    check("respawn_no_requeue", mv_cnt, 0);
    set_btns(4'b0000);
    for (int j = 0; j < 10; j++) step();

    // Reset asserted while in HOLD takes effect without a clock edge.
    set_btns(4'b1000);
    for (int j = 0; j < 20; j++) step();
    check("hold_row", int'(bus.row), 13);
    check("hold_moving", int'(bus.moving), 0);
    #2 reset = 1'b1;
    #1;
    check_pos("async_rst", 10, 14);
    check("async_rst_moving", int'(bus.moving), 0);
    set_btns(4'b0000);
    step(); step();
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
